sdr_init_seq: RTL and testbench
===============================

SDR_INIT_SEQ -- requirements
Module: sdr_init_seq

Interface
REQ-001 Parameters SHALL be: PWRUP_CYCLES, 8, power-up wait cycles (1..65535); TRP, 2, precharge-to-command cycles (>=1); TRFC, 4, refresh-to-command cycles (>=1); TMRD, 2, mode-register-to-command cycles (>=1); NREF, 2, auto-refresh commands issued (1..15).
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 Port: sdram_clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port: sdram_reset  input  1  synchronous active-high reset.
REQ-005 Port: reinit  input  1  pulse requesting a re-initialisation.
REQ-006 Port: cfg_cas_lat  input  2  CAS latency written to mode register A6:A4 (low 2 bits).
REQ-007 Port: cfg_burst_len  input  3  burst-length code written to mode register A2:A0.
REQ-008 Ports: sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  output  1 each  registered SDRAM control.
REQ-009 Ports: sdr_ba  output  2; sdr_addr  output  13  registered SDRAM bank/address.
REQ-010 Port: sdr_init_done  output  1  high once the sequence completes; feeds sdr_bus.

Function
REQ-011 All outputs SHALL be registered; command encoding {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE 0000.
REQ-012 States SHALL be WAIT_PWRUP, PRECHARGE, WAIT_TRP, AUTO_REF, WAIT_TRFC, LOAD_MODE, WAIT_TMRD, DONE.
REQ-013 WAIT_PWRUP SHALL last PWRUP_CYCLES cycles driving NOP; sdr_cke=0 for all but the last cycle, sdr_cke=1 in the last.
REQ-014 sdr_cke SHALL remain 1 in every state after WAIT_PWRUP.
REQ-015 PRECHARGE SHALL last one cycle: PRECHARGE command, sdr_addr[10]=1 (all banks), sdr_ba=00, other address bits 0.
REQ-016 WAIT_TRP SHALL drive NOP for TRP-1 cycles (skipped when TRP=1), then enter AUTO_REF.
REQ-017 AUTO_REF SHALL last one cycle issuing AUTO_REFRESH, sdr_ba=00, sdr_addr=0; WAIT_TRFC then drives NOP for TRFC-1 cycles.
REQ-018 After WAIT_TRFC a 4-bit refresh counter SHALL return to AUTO_REF until NREF refreshes are issued, then enter LOAD_MODE.
REQ-019 LOAD_MODE SHALL last one cycle issuing LOAD_MODE, sdr_ba=00, sdr_addr = {3'b000, 1'b0, 2'b00, 1'b0, cfg_cas_lat, 1'b0, cfg_burst_len} sampled in that cycle's setup.
REQ-020 cfg_cas_lat=00 SHALL be coerced to 2'b11 in the written mode value; cfg_burst_len SHALL pass unmodified.
REQ-021 WAIT_TMRD SHALL drive NOP for TMRD-1 cycles, then enter DONE.
REQ-022 In DONE: sdr_init_done=1, NOP, sdr_ba=00, sdr_addr=0.
REQ-023 reinit=1 while in DONE SHALL clear sdr_init_done in the next cycle and enter PRECHARGE (power-up wait skipped, cke stays 1).
REQ-024 reinit in any state other than DONE SHALL be ignored and not queued.
REQ-025 Wait counters SHALL be 16-bit down-counters loaded on state entry; no terminal-count wrap.
REQ-026 Total cycles from reset release to sdr_init_done=1 SHALL equal PWRUP_CYCLES + TRP + NREF*TRFC + TMRD.

Reset
REQ-027 While sdram_reset=1: state WAIT_PWRUP, counters cleared, sdr_cke=0, command NOP, sdr_ba=00, sdr_addr=0, sdr_init_done=0.
REQ-028 Reset asserted in any state, including mid-sequence or DONE, SHALL take effect at the next edge and restart from WAIT_PWRUP.

Verification
REQ-029 Defaults, reset released at cycle 0 -> cke=0 cycles 0-6, cke=1 cycle 7; PRECHARGE cycle 8 with addr[10]=1; AUTO_REFRESH cycles 10 and 14; LOAD_MODE cycle 18; sdr_init_done=1 from cycle 20.
REQ-030 cfg_cas_lat=10, cfg_burst_len=011 -> LOAD_MODE sdr_addr=13'h023; cfg_cas_lat=00, cfg_burst_len=000 -> sdr_addr=13'h030.
REQ-031 TRP=TRFC=TMRD=1, NREF=1, PWRUP_CYCLES=1 -> commands on consecutive cycles 1,2,3; sdr_init_done=1 at cycle 4.
REQ-032 reinit pulse in DONE -> sdr_init_done=0 next cycle, PRECHARGE same cycle, cke stays 1, done again after TRP+NREF*TRFC+TMRD cycles; reinit during WAIT_TRFC -> no effect.
REQ-033 sdram_reset asserted during WAIT_TRFC -> next cycle cke=0, NOP, done=0; full sequence replays after release.
REQ-034 Bound to sdr_bus: sdr_bus monitor reports no COMMAND ASSERTION FAIL for bank 0 once sdr_init_done is high.

Source files
------------

// File: rtl/sdr_init_seq.sv
// SDRAM power-up initialisation sequencer: power-up wait, precharge-all,
// NREF auto-refreshes, mode-register load, then holds NOP with init_done.
module sdr_init_seq #(
    parameter int unsigned PWRUP_CYCLES = 8,
    parameter int unsigned TRP          = 2,
    parameter int unsigned TRFC         = 4,
    parameter int unsigned TMRD         = 2,
    parameter int unsigned NREF         = 2
) (
    input  logic        sdram_clk,
    input  logic        sdram_reset,
    input  logic        reinit,
    input  logic [1:0]  cfg_cas_lat,
    input  logic [2:0]  cfg_burst_len,
    output logic        sdr_cke,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic        sdr_init_done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned REF_W  = 4;
    localparam int unsigned ADDR_W = 13;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    // Wait loads are "cycles remaining after the current one".
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYCLES);
    localparam logic [CNT_W-1:0] TRP_LD   = (TRP  > 1) ? CNT_W'(TRP  - 2) : '0;
    localparam logic [CNT_W-1:0] TRFC_LD  = (TRFC > 1) ? CNT_W'(TRFC - 2) : '0;
    localparam logic [CNT_W-1:0] TMRD_LD  = (TMRD > 1) ? CNT_W'(TMRD - 2) : '0;
    localparam logic [REF_W-1:0] NREF_LD  = REF_W'(NREF);

    typedef enum logic [2:0] {
        WAIT_PWRUP,
        PRECHARGE,
        WAIT_TRP,
        AUTO_REF,
        WAIT_TRFC,
        LOAD_MODE,
        WAIT_TMRD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic                cke_q, cke_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [1:0]          ba_q, ba_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                done_q, done_d;
    logic [1:0]          cas_eff;
    logic [ADDR_W-1:0]   mode_word;

    // A CAS latency code of 0 is reserved, so it is promoted to 3.
    assign cas_eff   = (cfg_cas_lat == 2'b00) ? 2'b11 : cfg_cas_lat;
    assign mode_word = {3'b000, 1'b0, 2'b00, 1'b0, cas_eff, 1'b0, cfg_burst_len};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        cke_d   = 1'b1;
        cmd_d   = CMD_NOP;
        ba_d    = 2'b00;
        addr_d  = '0;
        done_d  = 1'b0;

        case (state_q)
            WAIT_PWRUP: begin
                if (cnt_q == '0) state_d = PRECHARGE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            PRECHARGE: begin
                ref_d = '0;
                cnt_d = TRP_LD;
                state_d = (TRP > 1) ? WAIT_TRP : AUTO_REF;
            end
            WAIT_TRP: begin
                if (cnt_q == '0) state_d = AUTO_REF;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            AUTO_REF: begin
                ref_d = ref_q + REF_W'(1);
                cnt_d = TRFC_LD;
                if (TRFC > 1)            state_d = WAIT_TRFC;
                else if (ref_d == NREF_LD) state_d = LOAD_MODE;
                else                     state_d = AUTO_REF;
            end
            WAIT_TRFC: begin
                if (cnt_q != '0)           cnt_d   = cnt_q - CNT_W'(1);
                else if (ref_q == NREF_LD) state_d = LOAD_MODE;
                else                       state_d = AUTO_REF;
            end
            LOAD_MODE: begin
                cnt_d   = TMRD_LD;
                state_d = (TMRD > 1) ? WAIT_TMRD : DONE;
            end
            WAIT_TMRD: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE: begin
                if (reinit) state_d = PRECHARGE;
            end
            default: begin
                state_d = WAIT_PWRUP;
                cnt_d   = PWRUP_LD;
            end
        endcase

        // Outputs are decoded from the next state so they align with it.
        case (state_d)
            WAIT_PWRUP: cke_d = (cnt_d == '0);
            PRECHARGE: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
            end
            AUTO_REF:  cmd_d = CMD_AREF;
            LOAD_MODE: begin
                cmd_d  = CMD_LMR;
                addr_d = mode_word;
            end
            DONE:      done_d = 1'b1;
            default:   cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state_q <= WAIT_PWRUP;
            cnt_q   <= PWRUP_LD;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            ba_q    <= 2'b00;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign sdr_cke       = cke_q;
    assign sdr_cs_n      = cmd_q[3];
    assign sdr_ras_n     = cmd_q[2];
    assign sdr_cas_n     = cmd_q[1];
    assign sdr_we_n      = cmd_q[0];
    assign sdr_ba        = ba_q;
    assign sdr_addr      = addr_q;
    assign sdr_init_done = done_q;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Randomized bench for sdr_init_seq: three parameterisations checked every
// cycle against a timeline model derived from the sequence durations.
module tb_sdr_init_seq;

    localparam int NDUT   = 3;
    localparam int NCYC   = 6000;
    localparam int P_PW   [NDUT] = '{8, 1, 3};
    localparam int P_TRP  [NDUT] = '{2, 1, 3};
    localparam int P_TRFC [NDUT] = '{4, 1, 2};
    localparam int P_TMRD [NDUT] = '{2, 1, 3};
    localparam int P_NREF [NDUT] = '{2, 1, 3};

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;

    logic        clk = 1'b0;
    logic        rst, reinit;
    logic [1:0]  cas;
    logic [2:0]  bl;
    logic        cke [NDUT], cs_n [NDUT], ras_n [NDUT], cas_n [NDUT], we_n [NDUT], done [NDUT];
    logic [1:0]  ba   [NDUT];
    logic [12:0] addr [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdr_init_seq u_dut0 (
        .sdram_clk(clk), .sdram_reset(rst), .reinit(reinit),
        .cfg_cas_lat(cas), .cfg_burst_len(bl),
        .sdr_cke(cke[0]), .sdr_cs_n(cs_n[0]), .sdr_ras_n(ras_n[0]),
        .sdr_cas_n(cas_n[0]), .sdr_we_n(we_n[0]), .sdr_ba(ba[0]),
        .sdr_addr(addr[0]), .sdr_init_done(done[0]));

    sdr_init_seq #(.PWRUP_CYCLES(1), .TRP(1), .TRFC(1), .TMRD(1), .NREF(1)) u_dut1 (
        .sdram_clk(clk), .sdram_reset(rst), .reinit(reinit),
        .cfg_cas_lat(cas), .cfg_burst_len(bl),
        .sdr_cke(cke[1]), .sdr_cs_n(cs_n[1]), .sdr_ras_n(ras_n[1]),
        .sdr_cas_n(cas_n[1]), .sdr_we_n(we_n[1]), .sdr_ba(ba[1]),
        .sdr_addr(addr[1]), .sdr_init_done(done[1]));

    sdr_init_seq #(.PWRUP_CYCLES(3), .TRP(3), .TRFC(2), .TMRD(3), .NREF(3)) u_dut2 (
        .sdram_clk(clk), .sdram_reset(rst), .reinit(reinit),
        .cfg_cas_lat(cas), .cfg_burst_len(bl),
        .sdr_cke(cke[2]), .sdr_cs_n(cs_n[2]), .sdr_ras_n(ras_n[2]),
        .sdr_cas_n(cas_n[2]), .sdr_we_n(we_n[2]), .sdr_ba(ba[2]),
        .sdr_addr(addr[2]), .sdr_init_done(done[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int seq_len(input int d, input bit pw);
        return (pw ? P_PW[d] : 0) + P_TRP[d] + P_NREF[d] * P_TRFC[d] + P_TMRD[d];
    endfunction

    function automatic logic [12:0] mode_of(input logic [1:0] c, input logic [2:0] b);
        logic [1:0] ce;
        ce = (c == 2'b00) ? 2'b11 : c;
        return {6'd0, 1'b0, ce, 1'b0, b};
    endfunction

    // Expected {cke, cmd, ba, addr, done} at cycle k of a sequence (k<0: in reset).
    function automatic logic [20:0] model_out(input int d, input int k, input bit pw,
                                              input logic [12:0] mode);
        int t;
        bit placed;
        logic c_ke;
        logic [3:0] cmd;
        logic [12:0] a;
        logic dn;
        if (k < 0) return {1'b0, NOP, 2'b00, 13'h0, 1'b0};
        c_ke = 1'b1; cmd = NOP; a = 13'h0; dn = 1'b0; t = k; placed = 1'b0;
        if (pw) begin
            if (t < P_PW[d]) begin c_ke = (t == P_PW[d] - 1); placed = 1'b1; end
            else t -= P_PW[d];
        end
        if (!placed) begin
            if (t == 0) begin cmd = PRE; a = 13'h400; placed = 1'b1; end
            else if (t < P_TRP[d]) placed = 1'b1;
            else t -= P_TRP[d];
        end
        for (int i = 0; i < P_NREF[d]; i++) begin
            if (!placed) begin
                if (t == 0) begin cmd = AREF; placed = 1'b1; end
                else if (t < P_TRFC[d]) placed = 1'b1;
                else t -= P_TRFC[d];
            end
        end
        if (!placed) begin
            if (t == 0) begin cmd = LMR; a = mode; placed = 1'b1; end
            else if (t < P_TMRD[d]) placed = 1'b1;
            else t -= P_TMRD[d];
        end
        if (!placed) dn = 1'b1;
        return {c_ke, cmd, 2'b00, a, dn};
    endfunction

    initial begin
        int          k      [NDUT];
        bit          pw     [NDUT];
        logic [12:0] mode_x [NDUT];
        logic [20:0] exp_v, got_v;

        rst = 1'b1; reinit = 1'b0; cas = 2'b00; bl = 3'b000;
        for (int d = 0; d < NDUT; d++) begin
            k[d] = -1; pw[d] = 1'b1; mode_x[d] = 13'h0;
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (rst) begin
                    k[d] = -1; pw[d] = 1'b1;
                end else if (k[d] < 0) begin
                    k[d] = 0; pw[d] = 1'b1;
                end else if (k[d] >= seq_len(d, pw[d])) begin
                    if (reinit) begin k[d] = 0; pw[d] = 1'b0; end
                end else begin
                    k[d]++;
                end
                exp_v = model_out(d, k[d], pw[d], 13'h0);
                if (exp_v[19:16] == LMR && k[d] >= 0) mode_x[d] = mode_of(cas, bl);
            end

            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                exp_v = model_out(d, k[d], pw[d], mode_x[d]);
                got_v = {cke[d], cs_n[d], ras_n[d], cas_n[d], we_n[d], ba[d], addr[d], done[d]};
                check_eq($sformatf("dut%0d cyc%0d k%0d {cke,cmd,ba,addr,done}", d, cyc, k[d]),
                         32'(got_v), 32'(exp_v));
            end

            if (cyc < 3) rst = 1'b1;
            else rst = ($urandom_range(0, 249) == 0) || (rst && ($urandom_range(0, 1) == 0));
            reinit = ($urandom_range(0, 5) == 0);
            cas    = 2'($urandom);
            bl     = 3'($urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
